// File: rtl/gray_writer_pkg.sv
// Shared types and constants for the grayscale frame writer.
package gray_writer_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WRITE    = 2'd1,
        S_DRAIN    = 2'd2,
        S_WAIT_ACK = 2'd3
    } state_e;

    // BT.601-style luma weights scaled by 256; they sum to exactly 256.
    localparam int unsigned COEF_R     = 77;
    localparam int unsigned COEF_G     = 150;
    localparam int unsigned COEF_B     = 29;
    localparam int unsigned GRAY_SHIFT = 8;
    localparam int unsigned PROD_WIDTH = 16;

endpackage

// File: rtl/rgb_to_gray.sv
// Two-stage RGB888 to 8-bit luma pipeline with a valid/address sideband.
module rgb_to_gray
    import gray_writer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 17
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    input  logic [3*DATA_WIDTH-1:0] in_rgb,
    output logic                    out_valid,
    output logic [ADDR_WIDTH-1:0]   out_addr,
    output logic [DATA_WIDTH-1:0]   out_gray
);

    logic [PROD_WIDTH-1:0] prod_r_q, prod_g_q, prod_b_q;
    logic [PROD_WIDTH-1:0] sum_c;
    logic [ADDR_WIDTH-1:0] addr1_q;
    logic                  valid1_q;

    assign sum_c = prod_r_q + prod_g_q + prod_b_q;

    // Stage 1: weighted channel products.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid1_q <= 1'b0;
            addr1_q  <= '0;
            prod_r_q <= '0;
            prod_g_q <= '0;
            prod_b_q <= '0;
        end else begin
            valid1_q <= in_valid;
            if (in_valid) begin
                addr1_q  <= in_addr;
                prod_r_q <= PROD_WIDTH'(COEF_R) * PROD_WIDTH'(in_rgb[3*DATA_WIDTH-1 -: DATA_WIDTH]);
                prod_g_q <= PROD_WIDTH'(COEF_G) * PROD_WIDTH'(in_rgb[2*DATA_WIDTH-1 -: DATA_WIDTH]);
                prod_b_q <= PROD_WIDTH'(COEF_B) * PROD_WIDTH'(in_rgb[DATA_WIDTH-1 -: DATA_WIDTH]);
            end
        end
    end

    // Stage 2: sum and rescale; weights sum to 256 so the result never exceeds 255.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_gray  <= '0;
        end else begin
            out_valid <= valid1_q;
            if (valid1_q) begin
                out_addr <= addr1_q;
                out_gray <= DATA_WIDTH'(sum_c >> GRAY_SHIFT);
            end
        end
    end

endmodule

// File: rtl/gray_frame_writer.sv
// Converts streamed RGB pixels to gray, writes them into a double-buffered
// frame BRAM and publishes completed frames to the consumer with bank swapping.
module gray_frame_writer
    import gray_writer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned IMG_WIDTH       = 176,
    parameter int unsigned IMG_HEIGHT      = 240,
    parameter int unsigned TOTAL_PIXELS    = IMG_WIDTH * IMG_HEIGHT,
    parameter int unsigned PIXEL_CNT_WIDTH = $clog2(TOTAL_PIXELS),
    parameter int unsigned ADDR_WIDTH      = $clog2(2 * TOTAL_PIXELS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [3*DATA_WIDTH-1:0]    rgb_data,
    input  logic                       pixel_done,
    input  logic [PIXEL_CNT_WIDTH-1:0] pixel_cnt,
    input  logic                       frame_done,
    output logic                       wr_en,
    output logic [ADDR_WIDTH-1:0]      wr_addr,
    output logic [DATA_WIDTH-1:0]      wr_data,
    output logic                       frame_valid,
    output logic                       rd_bank,
    input  logic                       frame_ack,
    output logic                       seq_err,
    output logic                       ovf_err,
    output logic                       busy
);

    localparam logic [PIXEL_CNT_WIDTH-1:0] LAST_IDX   = PIXEL_CNT_WIDTH'(TOTAL_PIXELS - 1);
    localparam logic [ADDR_WIDTH-1:0]      BANK1_BASE = ADDR_WIDTH'(TOTAL_PIXELS);

    state_e                     state_q;
    logic [PIXEL_CNT_WIDTH-1:0] expected_q;
    logic                       rd_bank_q, frame_valid_q, seq_err_q, ovf_err_q, busy_q;

    logic                       accept_c, drain_done_c;
    logic [ADDR_WIDTH-1:0]      bank_base_c, pix_addr_c, last_addr_c;

    // Writes always target the bank the consumer is not reading.
    assign bank_base_c  = rd_bank_q ? '0 : BANK1_BASE;
    assign pix_addr_c   = bank_base_c + ADDR_WIDTH'(pixel_cnt);
    assign last_addr_c  = bank_base_c + ADDR_WIDTH'(LAST_IDX);
    assign accept_c     = pixel_done &&
                          (((state_q == S_IDLE)  && (pixel_cnt == '0)) ||
                           ((state_q == S_WRITE) && (pixel_cnt == expected_q)));
    assign drain_done_c = (state_q == S_DRAIN) && wr_en && (wr_addr == last_addr_c);

    rgb_to_gray #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rgb_to_gray (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (accept_c),
        .in_addr   (pix_addr_c),
        .in_rgb    (rgb_data),
        .out_valid (wr_en),
        .out_addr  (wr_addr),
        .out_gray  (wr_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            expected_q    <= '0;
            rd_bank_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            seq_err_q     <= 1'b0;
            ovf_err_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            // An ack releases the read bank; a swap later in this block overrides it.
            if (frame_ack) frame_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (pixel_done) begin
                        if (pixel_cnt == '0) begin
                            expected_q <= PIXEL_CNT_WIDTH'(1);
                            state_q    <= S_WRITE;
                            busy_q     <= 1'b1;
                        end else begin
                            seq_err_q  <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (accept_c && (pixel_cnt == LAST_IDX)) begin
                        expected_q <= '0;
                        state_q    <= S_DRAIN;
                    end else if (frame_done || (pixel_done && !accept_c)) begin
                        seq_err_q  <= 1'b1;
                        expected_q <= '0;
                        state_q    <= S_IDLE;
                        busy_q     <= 1'b0;
                    end else if (accept_c) begin
                        expected_q <= expected_q + PIXEL_CNT_WIDTH'(1);
                    end
                end
                S_DRAIN: begin
                    if (pixel_done) ovf_err_q <= 1'b1;
                    if (drain_done_c) begin
                        if (!frame_valid_q || frame_ack) begin
                            rd_bank_q     <= ~rd_bank_q;
                            frame_valid_q <= 1'b1;
                            state_q       <= S_IDLE;
                            busy_q        <= 1'b0;
                        end else begin
                            state_q       <= S_WAIT_ACK;
                        end
                    end
                end
                S_WAIT_ACK: begin
                    if (pixel_done) ovf_err_q <= 1'b1;
                    if (frame_ack) begin
                        rd_bank_q     <= ~rd_bank_q;
                        frame_valid_q <= 1'b1;
                        state_q       <= S_IDLE;
                        busy_q        <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign frame_valid = frame_valid_q;
    assign rd_bank     = rd_bank_q;
    assign seq_err     = seq_err_q;
    assign ovf_err     = ovf_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_gray_frame_writer.sv
// Directed bench for gray_frame_writer on a 4x2 image (8 pixels per frame).
module tb_gray_frame_writer;

    localparam int unsigned NPIX = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] rgb_data = '0;
    logic        pixel_done = 1'b0;
    logic [2:0]  pixel_cnt = '0;
    logic        frame_done = 1'b0;
    logic        frame_ack = 1'b0;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        frame_valid, rd_bank, seq_err, ovf_err, busy;

    int          errors = 0;
    int          checks = 0;
    logic [23:0] px [2][NPIX];
    logic [7:0]  gy [2][NPIX];
    logic [3:0]  wa_q [$];
    logic [7:0]  wd_q [$];

    gray_frame_writer #(
        .DATA_WIDTH (8),
        .IMG_WIDTH  (4),
        .IMG_HEIGHT (2)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .rgb_data    (rgb_data),
        .pixel_done  (pixel_done),
        .pixel_cnt   (pixel_cnt),
        .frame_done  (frame_done),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_valid (frame_valid),
        .rd_bank     (rd_bank),
        .frame_ack   (frame_ack),
        .seq_err     (seq_err),
        .ovf_err     (ovf_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Log every BRAM write once per cycle.
    always @(negedge clk) begin
        if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        pixel_done = 1'b0;
        frame_done = 1'b0;
        frame_ack  = 1'b0;
        rst_n      = 1'b0;
        tick();
        tick();
        rst_n      = 1'b1;
        tick();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic send_pixels(input int sel, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            pixel_done = 1'b1;
            pixel_cnt  = 3'(i);
            rgb_data   = px[sel][i];
            tick();
        end
        pixel_done = 1'b0;
    endtask

    // Full frame; optionally acks in the cycle of the last write.
    task automatic send_frame(input int sel, input bit ack_last, input string tag);
        send_pixels(sel, 0, NPIX - 1);
        tick();
        check_eq({tag, "_last_wr"}, 32'(wr_en), 32'd1);
        frame_ack = ack_last;
        tick();
        frame_ack = 1'b0;
    endtask

    task automatic check_writes(input int sel, input int base, input int n, input string tag);
        logic [3:0] a;
        logic [7:0] d;
        check_eq({tag, "_nwr"}, 32'(wa_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (wa_q.size() > 0) begin
                a = wa_q.pop_front();
                d = wd_q.pop_front();
                check_eq($sformatf("%s_addr%0d", tag, i), 32'(a), 32'(base + i));
                check_eq($sformatf("%s_data%0d", tag, i), 32'(d), 32'(gy[sel][i]));
            end
        end
        wa_q.delete();
        wd_q.delete();
    endtask

    initial begin
        px[0] = '{24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF,
                  24'h000000, 24'h000000, 24'h000000, 24'h000000};
        gy[0] = '{8'd255, 8'd76, 8'd149, 8'd28, 8'd0, 8'd0, 8'd0, 8'd0};
        px[1] = '{24'h808080, 24'h404040, 24'h102030, 24'h0A0B0C,
                  24'hFF00FF, 24'h00FFFF, 24'hFFFF00, 24'h123456};
        gy[1] = '{8'd128, 8'd64, 8'd29, 8'd10, 8'd105, 8'd178, 8'd226, 8'd45};

        // 1: first frame, latency and publish
        do_reset();
        check_eq("t1_reset_outs", 32'({wr_en, wr_addr, wr_data, frame_valid, rd_bank,
                                        seq_err, ovf_err, busy}), 32'd0);
        pixel_done = 1'b1; pixel_cnt = 3'd0; rgb_data = px[0][0];
        tick();
        check_eq("t1_lat_n1_wr_en", 32'(wr_en), 32'd0);
        check_eq("t1_busy", 32'(busy), 32'd1);
        pixel_cnt = 3'd1; rgb_data = px[0][1];
        tick();
        check_eq("t1_lat_n2_wr_en", 32'(wr_en), 32'd1);
        check_eq("t1_lat_n2_addr", 32'(wr_addr), 32'd8);
        check_eq("t1_lat_n2_data", 32'(wr_data), 32'd255);
        send_pixels(0, 2, NPIX - 1);
        tick();
        check_eq("t1_last_wr", 32'(wr_en), 32'd1);
        check_eq("t1_fv_before", 32'(frame_valid), 32'd0);
        tick();
        check_eq("t1_fv", 32'(frame_valid), 32'd1);
        check_eq("t1_rd_bank", 32'(rd_bank), 32'd1);
        check_eq("t1_busy_idle", 32'(busy), 32'd0);
        check_writes(0, 8, NPIX, "t1");

        // 2: second frame without ack holds in wait state
        send_frame(1, 1'b0, "t2");
        check_eq("t2_busy_wait", 32'(busy), 32'd1);
        check_eq("t2_rd_bank_hold", 32'(rd_bank), 32'd1);
        check_writes(1, 0, NPIX, "t2");
        pixel_done = 1'b1; pixel_cnt = 3'd0; rgb_data = px[0][0];
        tick();
        pixel_done = 1'b0;
        check_eq("t2_ovf", 32'(ovf_err), 32'd1);
        tick();
        tick();
        check_eq("t2_ovf_no_wr", 32'(wa_q.size()), 32'd0);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        check_eq("t2_ack_rd_bank", 32'(rd_bank), 32'd0);
        check_eq("t2_ack_fv", 32'(frame_valid), 32'd1);
        check_eq("t2_ack_busy", 32'(busy), 32'd0);

        // 3: index mismatch aborts, then a clean frame publishes
        send_pixels(0, 0, 2);
        pixel_done = 1'b1; pixel_cnt = 3'd5; rgb_data = px[0][5];
        tick();
        pixel_done = 1'b0;
        check_eq("t3_seq_err", 32'(seq_err), 32'd1);
        check_eq("t3_busy", 32'(busy), 32'd0);
        tick(); tick(); tick();
        check_writes(0, 8, 3, "t3_partial");
        check_eq("t3_rd_bank", 32'(rd_bank), 32'd0);
        check_eq("t3_fv", 32'(frame_valid), 32'd1);
        frame_ack = 1'b1;
        tick();
        check_eq("t3_ack_clears_fv", 32'(frame_valid), 32'd0);
        tick();
        frame_ack = 1'b0;
        check_eq("t3_ack_idle_fv", 32'(frame_valid), 32'd0);
        check_eq("t3_ack_idle_bank", 32'(rd_bank), 32'd0);
        send_frame(1, 1'b0, "t3");
        check_eq("t3_pub_rd_bank", 32'(rd_bank), 32'd1);
        check_eq("t3_pub_fv", 32'(frame_valid), 32'd1);
        check_eq("t3_pub_busy", 32'(busy), 32'd0);
        check_writes(1, 8, NPIX, "t3");

        // 4: idle drops, ignored frame_done, early frame_done abort
        do_reset();
        check_eq("t4_reset_outs", 32'({wr_en, frame_valid, rd_bank, seq_err, ovf_err, busy}), 32'd0);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        check_eq("t4_fd_idle", 32'({busy, seq_err}), 32'd0);
        pixel_done = 1'b1; pixel_cnt = 3'd3; rgb_data = px[1][3];
        tick();
        pixel_done = 1'b0;
        check_eq("t4_idle_drop_seq", 32'(seq_err), 32'd1);
        tick(); tick();
        check_eq("t4_idle_drop_no_wr", 32'(wa_q.size()), 32'd0);
        check_eq("t4_idle_drop_busy", 32'(busy), 32'd0);
        do_reset();
        send_pixels(1, 0, 4);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        check_eq("t4_early_fd_seq", 32'(seq_err), 32'd1);
        check_eq("t4_early_fd_busy", 32'(busy), 32'd0);
        tick(); tick(); tick();
        check_writes(1, 8, 5, "t4_partial");
        check_eq("t4_no_pub", 32'({frame_valid, rd_bank}), 32'd0);

        // 5: ack coincides with last write while a frame is published
        send_frame(0, 1'b0, "t5a");
        check_eq("t5a_pub", 32'({frame_valid, rd_bank, busy}), 32'b110);
        check_writes(0, 8, NPIX, "t5a");
        send_frame(1, 1'b1, "t5b");
        check_eq("t5b_rd_bank", 32'(rd_bank), 32'd0);
        check_eq("t5b_fv", 32'(frame_valid), 32'd1);
        check_eq("t5b_no_wait", 32'(busy), 32'd0);
        check_writes(1, 0, NPIX, "t5b");

        // 6: reset mid-frame kills the pipeline
        send_pixels(0, 0, 6);
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_outs", 32'({wr_en, wr_addr, wr_data, frame_valid, rd_bank,
                                        seq_err, ovf_err, busy}), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check_writes(0, 8, 5, "t6_partial");
        send_frame(1, 1'b0, "t6");
        check_eq("t6_pub", 32'({frame_valid, rd_bank, busy}), 32'b110);
        check_writes(1, 8, NPIX, "t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
